// File: rtl/mem_read_arbiter_if.sv
// Port bundle for mem_read_arbiter: two read requesters plus the shared
// memory read port. The arbiter connects through the slave modport; the
// requesters and the memory connect through the master modport.
interface mem_read_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 16
);
  // Requester 0 (APF bridge unloader)
  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  ack0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  // Requester 1 (bulk reader)
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  ack1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  // Shared memory read port and status
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport master (
    output req0, addr0, req1, addr1, mem_rdata,
    input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
    input  mem_rd, mem_addr, busy
  );

  modport slave (
    input  req0, addr0, req1, addr1, mem_rdata,
    output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
    output mem_rd, mem_addr, busy
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter for one fixed-latency memory read port.
// Round-robin with a bounded burst per owner; one read issued per clock.
// A {valid, owner} tag travels alongside each read so the returning word
// is steered to the requester that issued it.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_BURST   = 4
) (
  input logic               clk_memory,
  input logic               reset,
  mem_read_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  // Stage 0 is loaded together with mem_rd; the word for that read is on
  // mem_rdata while the tag sits in stage MEM_LATENCY, so it is captured
  // on the edge that retires that stage.
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // Arbitration state
  logic       last_owner_q, last_owner_d;
  logic [3:0] burst_cnt_q,  burst_cnt_d;

  // Grant decision for the current edge
  logic grant;
  logic grant_id;

  // Registered outputs
  logic                  mem_rd_q,   mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  ack0_q,     ack0_d;
  logic                  ack1_q,     ack1_d;
  logic                  rvalid0_q,  rvalid0_d;
  logic                  rvalid1_q,  rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q,   rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q,   rdata1_d;
  logic                  busy_q,     busy_d;

  // Tag pipeline
  tag_t [MEM_LATENCY:0] tag_q, tag_d;

  // Round-robin arbitration with a bounded burst for the current owner.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    grant        = 1'b0;
    grant_id     = 1'b0;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;

    case ({bus.req1, bus.req0})
      2'b00: begin
        burst_cnt_d = '0;
      end
      2'b01, 2'b10: begin
        grant    = 1'b1;
        grant_id = bus.req1;
        if ((grant_id == last_owner_q) && (burst_cnt_q != '0)) begin
          burst_cnt_d = (burst_cnt_q >= MAX_BURST_C) ? MAX_BURST_C
                                                     : burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = 4'd1;
        end
      end
      default: begin
        // Both requesting: stay with the owner until its burst is used up.
        grant = 1'b1;
        if ((burst_cnt_q != '0) && (burst_cnt_q < MAX_BURST_C)) begin
          grant_id    = last_owner_q;
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          grant_id    = ~last_owner_q;
          burst_cnt_d = 4'd1;
        end
      end
    endcase

    if (grant) begin
      last_owner_d = grant_id;
    end
  end

  // Issue side: memory strobe, address and acknowledge pulses.
  always_comb begin
    mem_rd_d   = grant;
    mem_addr_d = mem_addr_q;
    ack0_d     = grant & ~grant_id;
    ack1_d     = grant &  grant_id;
    if (grant) begin
      mem_addr_d = grant_id ? bus.addr1 : bus.addr0;
    end
  end

  // Tag shift and response steering; rdata holds until its next response.
  always_comb begin
    tag_d[0].valid = grant;
    tag_d[0].owner = grant_id;
    for (int i = 1; i <= MEM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    rvalid0_d = tag_q[MEM_LATENCY].valid & ~tag_q[MEM_LATENCY].owner;
    rvalid1_d = tag_q[MEM_LATENCY].valid &  tag_q[MEM_LATENCY].owner;
    rdata0_d  = rvalid0_d ? bus.mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_rdata : rdata1_q;

    // Stage 0 mirrors mem_rd, so this also covers the read being issued.
    busy_d = 1'b0;
    for (int i = 0; i <= MEM_LATENCY; i++) begin
      busy_d = busy_d | tag_d[i].valid;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_memory) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
      // NOTE: the tag pipeline is small flops, not a RAM, so it is cleared
      // here; that is what discards reads in flight across a reset.
      tag_q        <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = busy_q;

endmodule
